mmu_read_arbiter: RTL and testbench
===================================

# mmu_read_arbiter

Sequential arbiter that shares the single AXI read address/data channel between the MMU instruction requester and the data requester. It replaces combinational read-channel muxing with a locked grant. The grant holds from AR issue until the last R beat, so beats are never steered to the wrong requester. Data has priority, with a bounded-starvation guarantee for instruction fetch. It sits between `mmu_inst`/`mmu_data` and the AXI master port; the write channel is out of scope.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants issued while inst is waiting. Legal range ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `i_req_valid` input 1: inst read request. Held until `i_req_ready`.
- `i_req_addr` input 32: inst physical address.
- `i_req_single` input 1: 1 = single beat (arlen 0, FIXED); 0 = 16-beat INCR line fill.
- `i_req_ready` output 1: pulse when the inst AR handshake completes.
- `i_rdata` output 32: read data to inst.
- `i_rvalid` output 1: beat valid to inst.
- `i_rlast` output 1: last beat to inst.
- `i_rerr` output 1: on the last beat, high if any beat of the burst had `rresp`≠0 or a `rid` mismatch.
- `d_req_valid`, `d_req_addr`, `d_req_single`, `d_req_ready`, `d_rdata`, `d_rvalid`, `d_rlast`, `d_rerr`: same as the inst set, for the data requester.
- `arid` output 4: 0 for inst, 1 for data.
- `araddr` output 32.
- `arlen` output 8: 0 or 15.
- `arsize` output 3: constant 3'b010.
- `arburst` output 2: 0 (FIXED) for single, 1 (INCR) for burst.
- `arvalid` output 1.
- `arready` input 1.
- `rid` input 4.
- `rdata` input 32.
- `rresp` input 2.
- `rlast` input 1.
- `rvalid` input 1.
- `rready` output 1.

## Operation
- FSM states: IDLE, ADDR, DATA. Reset enters IDLE.
- IDLE: if neither request is valid, stay in IDLE.
  - If only one is valid, grant it.
  - If both are valid, grant data unless `starve_cnt == STARVE_LIMIT`, in which case grant inst.
  - On a grant: register `grant`, `araddr`, `arlen`, `arburst`, `arid` from the winner, clear `err_acc` and `beat_cnt`, and go to ADDR.
- ADDR: `arvalid`=1 with the registered fields held stable.
  - On `arready`: pulse the granted `*_req_ready` in the same cycle and go to DATA.
  - `arvalid` never drops before `arready`.
- DATA: `rready`=1.
  - Each `rvalid` beat is forwarded combinationally (same cycle) to the granted requester only. The non-granted `*_rvalid`/`*_rlast` stay 0 and its `*_rdata` stays 0.
  - `beat_cnt` increments per beat.
  - `err_acc` ORs in `(rresp≠0) | (rid≠arid)`.
  - Forwarded `*_rlast` = `rlast`. `*_rerr` = `err_acc | current-beat error | (rlast && beat_cnt≠arlen)`, and is valid only on the last beat.
  - On `rvalid && rlast`, go to IDLE.
  - A beat with `beat_cnt == arlen` but `rlast`=0 is treated as last: forward it with `*_rlast`=1 and `*_rerr`=1, then go to IDLE.
- Starvation counter `starve_cnt`, width $clog2(STARVE_LIMIT+1), saturating:
  - Increments on a data grant while `i_req_valid`=1.
  - Clears on any inst grant, and on a data grant while `i_req_valid`=0.
- Only one transaction is outstanding at a time. A request arriving during ADDR or DATA waits for IDLE.
- `i_req_valid` dropping while not granted is legal; the request simply never wins.
- Reset mid-transaction: all state clears asynchronously and the outstanding AXI transaction is abandoned. The interconnect is reset by the same `rst`.

## Timing
- All outputs are 0 under reset, except `arsize`=3'b010. That includes `arvalid`, `rready`, both `*_req_ready`, the `*_rvalid`/`*_rlast`/`*_rerr` outputs, `araddr`, `arlen`, `arburst`, `arid`, and `starve_cnt`.
- Request sampled in IDLE at cycle N → `arvalid`=1 at N+1.
- `arready` at cycle M → `*_req_ready`=1 at M and `rready`=1 from M+1.
- Last beat at cycle L → IDLE at L+1. A pending request gives `arvalid` at L+2.
- Minimum back-to-back gap: one IDLE cycle between bursts.
- `rready`=0 in IDLE and ADDR. Beats presented then are not accepted, and none are forwarded.
- AXI: `araddr`, `arlen`, `arburst`, `arid` stay constant while `arvalid`=1 and `arready`=0.

## Test plan
- Single inst read, addr 0x1FC00000, `i_req_single`=1, `arready` at the first ADDR cycle, one beat 0xDEADBEEF with `rlast`:
  - `arlen`=0, `arburst`=0, `arid`=0, `i_req_ready` pulses once.
  - `i_rdata`=0xDEADBEEF with `i_rvalid`/`i_rlast`=1 and `i_rerr`=0. `d_rvalid` stays 0.
- Simultaneous inst and data bursts, with `arready` held low for 3 cycles:
  - Data is granted, `arid`=1, `arlen`=15.
  - `araddr` is stable for all 3 stall cycles.
  - All 16 beats go to the data requester only. Inst is granted 2 cycles after data's `rlast`.
- Both requesters continuously valid, `STARVE_LIMIT`=4: grant order is D,D,D,D,I,D,D,D,D,I.
- `rresp`=2'b10 on beat 7 of a 16-beat burst → `d_rerr`=1 on beat 15 only.
- Early `rlast` on beat 9 → `i_rerr`=1 with `i_rlast` on that beat, then back to IDLE.
- `rst` asserted low in the middle of DATA → `rready`, `arvalid` and all `*_rvalid` go to 0 immediately. After release the FSM is in IDLE and `starve_cnt`=0.

Source files
------------

// File: rtl/mmu_read_arbiter_if.sv
// Shared AXI read channel bundle between the MMU requesters, the arbiter and the AXI port.
// Each handshake completes in the cycle where valid and ready are both high.
// valid may not depend on ready, and once raised it holds with stable payload until that cycle.
interface mmu_read_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_single;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rlast;
  logic        i_rerr;

  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_single;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rlast;
  logic        d_rerr;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Arbiter side: it is the AXI master and the responder to both requesters.
  modport master (
    input  i_req_valid, i_req_addr, i_req_single,
    input  d_req_valid, d_req_addr, d_req_single,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    output i_req_ready, i_rdata, i_rvalid, i_rlast, i_rerr,
    output d_req_ready, d_rdata, d_rvalid, d_rlast, d_rerr,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  // Environment side: requesters plus the AXI interconnect.
  modport slave (
    output i_req_valid, i_req_addr, i_req_single,
    output d_req_valid, d_req_addr, d_req_single,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input  i_req_ready, i_rdata, i_rvalid, i_rlast, i_rerr,
    input  d_req_ready, d_rdata, d_rvalid, d_rlast, d_rerr,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/mmu_read_arbiter.sv
// Locked-grant arbiter sharing one AXI read channel between MMU inst and data requesters.
// Data wins ties except after STARVE_LIMIT consecutive data grants taken while inst waited.
module mmu_read_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mmu_read_arbiter_if.master  bus,
  output logic [1:0]          dbg_state_o,
  output logic [7:0]          dbg_starve_cnt_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;       // 1 = data requester owns the channel
  logic [31:0]   araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [1:0]    arburst_q, arburst_d;
  logic [3:0]    arid_q, arid_d;
  logic          err_acc_q, err_acc_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic beat;
  logic beat_err;
  logic cnt_end;
  logic last;
  logic fwd_err;
  logic starve_full;
  logic pick_inst;
  logic win_single;
  logic i_fwd;
  logic d_fwd;

  assign starve_full = (starve_cnt_q == SW'(STARVE_LIMIT));
  assign pick_inst   = bus.i_req_valid && (!bus.d_req_valid || starve_full);
  assign win_single  = pick_inst ? bus.i_req_single : bus.d_req_single;

  assign beat     = (state_q == DATA) && bus.rvalid;
  assign beat_err = (bus.rresp != 2'b00) || (bus.rid != arid_q);
  assign cnt_end  = (beat_cnt_q == arlen_q);
  // A burst ends on rlast or on the beat count reaching arlen; any disagreement is an error.
  assign last     = bus.rlast || cnt_end;
  assign fwd_err  = last && (err_acc_q || beat_err || (bus.rlast != cnt_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      araddr_q     <= 32'h0;
      arlen_q      <= 8'h0;
      arburst_q    <= 2'b00;
      arid_q       <= 4'h0;
      err_acc_q    <= 1'b0;
      beat_cnt_q   <= 8'h0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arburst_q    <= arburst_d;
      arid_q       <= arid_d;
      err_acc_q    <= err_acc_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arburst_d    = arburst_q;
    arid_d       = arid_q;
    err_acc_d    = err_acc_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req_valid || bus.d_req_valid) begin
          grant_d    = !pick_inst;
          araddr_d   = pick_inst ? bus.i_req_addr : bus.d_req_addr;
          arlen_d    = win_single ? 8'd0 : 8'd15;
          arburst_d  = win_single ? 2'b00 : 2'b01;
          arid_d     = pick_inst ? 4'd0 : 4'd1;
          err_acc_d  = 1'b0;
          beat_cnt_d = 8'h0;
          // Only data grants taken over a waiting inst request count toward starvation.
          if (!pick_inst && bus.i_req_valid) begin
            if (!starve_full) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus.arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          err_acc_d  = err_acc_q || beat_err;
          if (last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_fwd = beat && !grant_q;
  assign d_fwd = beat && grant_q;

  assign bus.arvalid     = (state_q == ADDR);
  assign bus.rready      = (state_q == DATA);
  assign bus.araddr      = araddr_q;
  assign bus.arlen       = arlen_q;
  assign bus.arburst     = arburst_q;
  assign bus.arid        = arid_q;
  assign bus.arsize      = 3'b010;

  assign bus.i_req_ready = (state_q == ADDR) && bus.arready && !grant_q;
  assign bus.d_req_ready = (state_q == ADDR) && bus.arready && grant_q;

  assign bus.i_rvalid    = i_fwd;
  assign bus.i_rlast     = i_fwd && last;
  assign bus.i_rerr      = i_fwd && fwd_err;
  assign bus.i_rdata     = i_fwd ? bus.rdata : 32'h0;

  assign bus.d_rvalid    = d_fwd;
  assign bus.d_rlast     = d_fwd && last;
  assign bus.d_rerr      = d_fwd && fwd_err;
  assign bus.d_rdata     = d_fwd ? bus.rdata : 32'h0;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = 8'(starve_cnt_q);

endmodule

// File: tb/tb_mmu_read_arbiter.sv
// Randomized self-checking bench for mmu_read_arbiter: a behavioural grant/error model
// plus an expected-data queue, with an AXI slave driver that records what the DUT forwards.
module tb_mmu_read_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [7:0] dbg_starve;

  mmu_read_arbiter_if bus();

  mmu_read_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .dbg_state_o      (dbg_state),
    .dbg_starve_cnt_o (dbg_starve)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_starve = 0;
  bit i_repeat = 0;
  bit d_repeat = 0;

  // Scoreboard and recorded observations of the most recent transaction
  logic [31:0] exp_q[$];
  logic [31:0] obs_data_q[$];
  int          obs_side_q[$];
  bit          obs_last_q[$];
  bit          obs_err_q[$];
  logic [3:0]  got_arid;
  logic [31:0] got_araddr;
  logic [7:0]  got_arlen;
  logic [1:0]  got_arburst;
  bit          stable_bad;
  bit          leak;
  bit          rready_bad;
  int          i_rdy_cnt;
  int          d_rdy_cnt;
  int          ar_seen_cyc;
  int          last_cyc;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim_time=%0t required=finish before 400000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.i_req_valid = 0; bus.i_req_addr = 0; bus.i_req_single = 0;
    bus.d_req_valid = 0; bus.d_req_addr = 0; bus.d_req_single = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.rlast = 0; bus.rvalid = 0;
  endtask

  task automatic request(input bit to_d, input logic [31:0] addr, input bit single);
    if (to_d) begin
      bus.d_req_valid = 1; bus.d_req_addr = addr; bus.d_req_single = single;
    end else begin
      bus.i_req_valid = 1; bus.i_req_addr = addr; bus.i_req_single = single;
    end
  endtask

  // Data wins unless inst has already been passed over STARVE_LIMIT times in a row.
  task automatic model_grant(input bit iv, input bit dv, output bit pick_d);
    pick_d = dv && !(iv && model_starve >= STARVE_LIMIT);
    if (pick_d && iv) model_starve = model_starve + 1;
    else model_starve = 0;
  endtask

  function automatic bit model_err(input int alen, input int err_beat, input int rlast_beat);
    return (err_beat >= 0) || (rlast_beat != alen);
  endfunction

  // AXI slave: waits for AR, stalls, accepts, then returns nbeats beats. Leaves time at a negedge.
  task automatic axi_serve(input int stall, input int nbeats, input int err_beat,
                           input bit err_rid, input int rlast_beat);
    bit          seen;
    bit          acc_i;
    bit          acc_d;
    int          side;
    logic [31:0] w;
    seen = 0;
    exp_q.delete(); obs_data_q.delete(); obs_side_q.delete();
    obs_last_q.delete(); obs_err_q.delete();
    stable_bad = 0; leak = 0; rready_bad = 0; i_rdy_cnt = 0; d_rdy_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      if (bus.arvalid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ar_timeout: arvalid=%0b required=1 within 64 cycles", bus.arvalid);
      return;
    end
    ar_seen_cyc = cyc;
    got_arid = bus.arid; got_araddr = bus.araddr; got_arlen = bus.arlen; got_arburst = bus.arburst;
    for (int s = 0; s < stall; s++) begin
      bus.arready = 0;
      #1;
      i_rdy_cnt += int'(bus.i_req_ready); d_rdy_cnt += int'(bus.d_req_ready);
      if (bus.rready !== 1'b0) rready_bad = 1;
      @(negedge clk);
      if (bus.arvalid !== 1'b1 || bus.arid !== got_arid || bus.araddr !== got_araddr ||
          bus.arlen !== got_arlen || bus.arburst !== got_arburst) stable_bad = 1;
    end
    bus.arready = 1;
    #1;
    acc_i = bus.i_req_ready; acc_d = bus.d_req_ready;
    i_rdy_cnt += int'(acc_i); d_rdy_cnt += int'(acc_d);
    if (bus.rready !== 1'b0) rready_bad = 1;
    @(negedge clk);
    bus.arready = 0;
    if (acc_i) begin
      if (i_repeat) bus.i_req_addr = $urandom; else bus.i_req_valid = 0;
    end
    if (acc_d) begin
      if (d_repeat) bus.d_req_addr = $urandom; else bus.d_req_valid = 0;
    end
    for (int b = 0; b < nbeats; b++) begin
      w = $urandom;
      bus.rvalid = 1;
      bus.rdata  = w;
      bus.rresp  = (b == err_beat && !err_rid) ? 2'b10 : 2'b00;
      bus.rid    = (b == err_beat && err_rid) ? 4'hA : got_arid;
      bus.rlast  = (b == rlast_beat);
      exp_q.push_back(w);
      #1;
      if (bus.rready !== 1'b1) rready_bad = 1;
      i_rdy_cnt += int'(bus.i_req_ready); d_rdy_cnt += int'(bus.d_req_ready);
      side = 2;
      if (bus.i_rvalid === 1'b1 && bus.d_rvalid === 1'b0) side = 0;
      else if (bus.d_rvalid === 1'b1 && bus.i_rvalid === 1'b0) side = 1;
      obs_side_q.push_back(side);
      obs_data_q.push_back(side == 0 ? bus.i_rdata : (side == 1 ? bus.d_rdata : 32'h0));
      obs_last_q.push_back(side == 0 ? bus.i_rlast : bus.d_rlast);
      obs_err_q.push_back(side == 0 ? bus.i_rerr : bus.d_rerr);
      if (side == 0 && (bus.d_rdata !== 32'h0 || bus.d_rlast !== 1'b0 || bus.d_rerr !== 1'b0)) leak = 1;
      if (side == 1 && (bus.i_rdata !== 32'h0 || bus.i_rlast !== 1'b0 || bus.i_rerr !== 1'b0)) leak = 1;
      last_cyc = cyc;
      @(negedge clk);
    end
    bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; bus.rdata = 0; bus.rid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 0;
    bus.rvalid = 1; bus.rdata = 32'hA5A5_5A5A; bus.rlast = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.rready, bus.i_req_ready, bus.d_req_ready} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: arvalid/rready/i_rdy/d_rdy=%b required=0000",
               {bus.arvalid, bus.rready, bus.i_req_ready, bus.d_req_ready});
    end
    checks++;
    if ({bus.i_rvalid, bus.i_rlast, bus.i_rerr, bus.d_rvalid, bus.d_rlast, bus.d_rerr} !== 6'b0 ||
        bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_fwd: flags=%b i_rdata=%h d_rdata=%h required=0",
               {bus.i_rvalid, bus.i_rlast, bus.i_rerr, bus.d_rvalid, bus.d_rlast, bus.d_rerr},
               bus.i_rdata, bus.d_rdata);
    end
    checks++;
    if (bus.araddr !== 32'h0 || bus.arlen !== 8'h0 || bus.arburst !== 2'b0 ||
        bus.arid !== 4'h0 || bus.arsize !== 3'b010) begin
      failures++;
      $display("FAIL reset_ar: araddr=%h arlen=%0d arburst=%0d arid=%0d arsize=%b required 0/0/0/0/010",
               bus.araddr, bus.arlen, bus.arburst, bus.arid, bus.arsize);
    end
    checks++;
    if (dbg_state !== 2'd0 || dbg_starve !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d starve=%0d required=0/0", dbg_state, dbg_starve);
    end
    clear_inputs();
    rst = 1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || bus.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state=%0d arvalid=%0b required=0/0", dbg_state, bus.arvalid);
    end
    model_starve = 0;
  endtask

  task automatic test_single_inst();
    bit pd;
    request(0, 32'h1FC0_0000, 1);
    model_grant(1, 0, pd);
    axi_serve(0, 1, -1, 0, 0);
    checks++;
    if (got_arlen !== 8'd0 || got_arburst !== 2'd0 || got_arid !== 4'd0 || got_araddr !== 32'h1FC0_0000) begin
      failures++;
      $display("FAIL single_ar: arlen=%0d arburst=%0d arid=%0d araddr=%h required 0/0/0/1fc00000",
               got_arlen, got_arburst, got_arid, got_araddr);
    end
    checks++;
    if (i_rdy_cnt !== 1 || d_rdy_cnt !== 0) begin
      failures++;
      $display("FAIL single_ready: i_pulses=%0d d_pulses=%0d required=1/0", i_rdy_cnt, d_rdy_cnt);
    end
    checks++;
    if (obs_side_q.size() !== 1 || obs_side_q[0] !== 0 || obs_data_q[0] !== exp_q[0] ||
        obs_last_q[0] !== 1'b1 || obs_err_q[0] !== 1'b0 || leak) begin
      failures++;
      $display("FAIL single_beat: n=%0d side=%0d data=%h last=%0b err=%0b leak=%0b required 1/0/%h/1/0/0",
               obs_side_q.size(), obs_side_q[0], obs_data_q[0], obs_last_q[0], obs_err_q[0], leak, exp_q[0]);
    end
  endtask

  task automatic test_contention();
    bit          pd;
    logic [31:0] ai;
    logic [31:0] ad;
    int          d_last;
    ai = $urandom; ad = $urandom;
    request(0, ai, 0);
    request(1, ad, 0);
    model_grant(1, 1, pd);
    axi_serve(3, 16, -1, 0, 15);
    d_last = last_cyc;
    checks++;
    if (got_arid !== 4'(pd) || got_arlen !== 8'd15 || got_arburst !== 2'd1 || got_araddr !== ad) begin
      failures++;
      $display("FAIL contention_ar: arid=%0d arlen=%0d arburst=%0d araddr=%h required %0d/15/1/%h",
               got_arid, got_arlen, got_arburst, got_araddr, pd, ad);
    end
    checks++;
    if (stable_bad || rready_bad || d_rdy_cnt !== 1 || i_rdy_cnt !== 0) begin
      failures++;
      $display("FAIL contention_stall: unstable=%0b rready_bad=%0b d_pulses=%0d i_pulses=%0d required 0/0/1/0",
               stable_bad, rready_bad, d_rdy_cnt, i_rdy_cnt);
    end
    checks++;
    if (obs_side_q.size() !== 16 || leak) begin
      failures++;
      $display("FAIL contention_count: beats=%0d leak=%0b required 16/0", obs_side_q.size(), leak);
    end
    for (int b = 0; b < obs_side_q.size(); b++) begin
      checks++;
      if (obs_side_q[b] !== 1 || obs_data_q[b] !== exp_q[b] || obs_last_q[b] !== (b == 15) || obs_err_q[b] !== 1'b0) begin
        failures++;
        $display("FAIL contention_beat%0d: side=%0d data=%h last=%0b err=%0b required 1/%h/%0b/0",
                 b, obs_side_q[b], obs_data_q[b], obs_last_q[b], obs_err_q[b], exp_q[b], b == 15);
      end
    end
    model_grant(1, 0, pd);
    axi_serve(0, 16, -1, 0, 15);
    checks++;
    if (got_arid !== 4'd0 || got_araddr !== ai || (ar_seen_cyc - d_last) !== 2) begin
      failures++;
      $display("FAIL contention_inst: arid=%0d araddr=%h gap=%0d required 0/%h/2",
               got_arid, got_araddr, ar_seen_cyc - d_last, ai);
    end
    checks++;
    if (obs_side_q.size() !== 16 || obs_side_q[15] !== 0 || obs_data_q[15] !== exp_q[15] || leak) begin
      failures++;
      $display("FAIL contention_inst_beats: beats=%0d side15=%0d leak=%0b required 16/0/0",
               obs_side_q.size(), obs_side_q[15], leak);
    end
  endtask

  task automatic test_starvation();
    bit          pd;
    logic [31:0] ai;
    logic [31:0] ad;
    int          want;
    i_repeat = 1; d_repeat = 1;
    request(0, $urandom, 1);
    request(1, $urandom, 1);
    for (int k = 0; k < 10; k++) begin
      ai = bus.i_req_addr; ad = bus.d_req_addr;
      want = (k % 5 == 4) ? 0 : 1;
      model_grant(1, 1, pd);
      axi_serve($urandom_range(0, 2), 1, -1, 0, 0);
      checks++;
      if (got_arid !== 4'(want) || got_araddr !== (want == 1 ? ad : ai)) begin
        failures++;
        $display("FAIL starve_order%0d: arid=%0d araddr=%h required %0d/%h",
                 k, got_arid, got_araddr, want, want == 1 ? ad : ai);
      end
      checks++;
      if (dbg_starve !== 8'(model_starve)) begin
        failures++;
        $display("FAIL starve_cnt%0d: starve=%0d required=%0d", k, dbg_starve, model_starve);
      end
    end
    i_repeat = 0; d_repeat = 0;
    bus.i_req_valid = 0; bus.d_req_valid = 0;
  endtask

  task automatic test_err_beat();
    bit pd;
    request(1, $urandom, 0);
    model_grant(0, 1, pd);
    axi_serve($urandom_range(0, 2), 16, 7, 0, 15);
    checks++;
    if (obs_side_q.size() !== 16 || got_arid !== 4'd1) begin
      failures++;
      $display("FAIL err_count: beats=%0d arid=%0d required 16/1", obs_side_q.size(), got_arid);
    end
    for (int b = 0; b < obs_side_q.size(); b++) begin
      checks++;
      if (obs_side_q[b] !== 1 || obs_err_q[b] !== (b == 15) || obs_last_q[b] !== (b == 15) || obs_data_q[b] !== exp_q[b]) begin
        failures++;
        $display("FAIL err_beat%0d: side=%0d err=%0b last=%0b data=%h required 1/%0b/%0b/%h",
                 b, obs_side_q[b], obs_err_q[b], obs_last_q[b], obs_data_q[b], b == 15, b == 15, exp_q[b]);
      end
    end
  endtask

  task automatic test_early_rlast();
    bit pd;
    request(0, $urandom, 0);
    model_grant(1, 0, pd);
    axi_serve(0, 10, -1, 0, 9);
    checks++;
    if (obs_side_q.size() !== 10 || obs_side_q[9] !== 0 || obs_last_q[9] !== 1'b1 || obs_err_q[9] !== 1'b1) begin
      failures++;
      $display("FAIL early_last: beats=%0d side=%0d last=%0b err=%0b required 10/0/1/1",
               obs_side_q.size(), obs_side_q[9], obs_last_q[9], obs_err_q[9]);
    end
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (obs_last_q[b] !== 1'b0 || obs_data_q[b] !== exp_q[b]) begin
        failures++;
        $display("FAIL early_beat%0d: last=%0b data=%h required 0/%h", b, obs_last_q[b], obs_data_q[b], exp_q[b]);
      end
    end
    checks++;
    if (dbg_state !== 2'd0 || bus.arvalid !== 1'b0 || bus.rready !== 1'b0) begin
      failures++;
      $display("FAIL early_idle: state=%0d arvalid=%0b rready=%0b required 0/0/0",
               dbg_state, bus.arvalid, bus.rready);
    end
  endtask

  task automatic test_reset_mid();
    bit pd;
    request(0, $urandom, 0);
    request(1, $urandom, 0);
    model_grant(1, 1, pd);
    axi_serve(0, 5, -1, 0, -1);
    bus.rvalid = 1; bus.rdata = $urandom; bus.rid = 4'd1; bus.rlast = 0;
    #1;
    checks++;
    if (bus.d_rvalid !== 1'b1 || dbg_starve !== 8'(model_starve)) begin
      failures++;
      $display("FAIL rstmid_pre: d_rvalid=%0b starve=%0d required 1/%0d", bus.d_rvalid, dbg_starve, model_starve);
    end
    rst = 0;
    #1;
    checks++;
    if ({bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid, bus.i_rlast, bus.d_rlast} !== 6'b0 ||
        bus.d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_async: arvalid/rready/i_rv/d_rv/i_rl/d_rl=%b d_rdata=%h required 0",
               {bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid, bus.i_rlast, bus.d_rlast}, bus.d_rdata);
    end
    clear_inputs();
    model_starve = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || dbg_starve !== 8'd0 || bus.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: state=%0d starve=%0d arvalid=%0b required 0/0/0", dbg_state, dbg_starve, bus.arvalid);
    end
  endtask

  task automatic test_random();
    bit          iv, dv, is, ds, pd, single, err_rid, exp_e;
    logic [31:0] ai, ad;
    int          mode, alen, err_beat, rlast_beat, nbeats;
    for (int t = 0; t < 24; t++) begin
      iv = 1'($urandom_range(0, 1)); dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) dv = 1;
      is = 1'($urandom_range(0, 1)); ds = 1'($urandom_range(0, 1));
      ai = $urandom; ad = $urandom;
      if (iv) request(0, ai, is);
      if (dv) request(1, ad, ds);
      model_grant(iv, dv, pd);
      single = pd ? ds : is;
      alen = single ? 0 : 15;
      mode = $urandom_range(0, 3);
      err_beat = -1; err_rid = 0; rlast_beat = alen;
      if (mode == 1) err_beat = $urandom_range(0, alen);
      if (mode == 2) begin err_beat = $urandom_range(0, alen); err_rid = 1; end
      if (mode == 3) rlast_beat = (alen == 15 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 14) : -1;
      nbeats = (rlast_beat >= 0) ? rlast_beat + 1 : alen + 1;
      exp_e = model_err(alen, err_beat, rlast_beat);
      axi_serve($urandom_range(0, 3), nbeats, err_beat, err_rid, rlast_beat);
      bus.i_req_valid = 0; bus.d_req_valid = 0;
      checks++;
      if (got_arid !== 4'(pd) || got_arlen !== 8'(alen) || got_arburst !== {1'b0, !single} ||
          got_araddr !== (pd ? ad : ai) || stable_bad || rready_bad) begin
        failures++;
        $display("FAIL rand%0d_ar: arid=%0d arlen=%0d arburst=%0d araddr=%h unstable=%0b required %0d/%0d/%0d/%h/0",
                 t, got_arid, got_arlen, got_arburst, got_araddr, stable_bad, pd, alen, !single, pd ? ad : ai);
      end
      checks++;
      if (i_rdy_cnt !== int'(!pd) || d_rdy_cnt !== int'(pd) || leak || obs_side_q.size() !== nbeats) begin
        failures++;
        $display("FAIL rand%0d_rdy: i_pulses=%0d d_pulses=%0d leak=%0b beats=%0d required %0d/%0d/0/%0d",
                 t, i_rdy_cnt, d_rdy_cnt, leak, obs_side_q.size(), !pd, pd, nbeats);
      end
      for (int b = 0; b < obs_side_q.size(); b++) begin
        checks++;
        if (obs_side_q[b] !== int'(pd) || obs_data_q[b] !== exp_q[b] || obs_last_q[b] !== (b == nbeats - 1) ||
            (b == nbeats - 1 && obs_err_q[b] !== exp_e)) begin
          failures++;
          $display("FAIL rand%0d_beat%0d: side=%0d data=%h last=%0b err=%0b required %0d/%h/%0b/%0b",
                   t, b, obs_side_q[b], obs_data_q[b], obs_last_q[b], obs_err_q[b],
                   pd, exp_q[b], b == nbeats - 1, exp_e);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    clear_inputs();
    rst = 0;
    @(negedge clk);
    test_reset();
    test_single_inst();
    test_contention();
    test_starvation();
    test_err_beat();
    test_early_rlast();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
